// File: rtl/store_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_exec_unit
// Description : Execute stage for S-type stores (SB/SH/SW). Forms the
//               effective address and byte-lane data, and issues a single
//               outstanding write request to data memory. The request ends
//               on mem_ack or on a timeout. Completion, misalignment,
//               illegal-funct3 and bus-timeout status are reported with a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module store_exec_unit #(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        imm_MSB,
    input  logic [4:0]        imm_LSB,
    input  logic [2:0]        funct3,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       rs2_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    output logic              done,
    output logic              misaligned,
    output logic              illegal,
    output logic              bus_err,
    output logic [ADDR_W-1:0] fault_addr
);

    localparam logic [2:0] c_F3_SB    = 3'b000;
    localparam logic [2:0] c_F3_SH    = 3'b001;
    localparam logic [2:0] c_F3_SW    = 3'b010;
    localparam logic [7:0] c_CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DONE  = 3'd2,
        ST_FAULT = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_eff;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_mis;
    logic              r_ill;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_fault_addr;

    logic [31:0]       w_imm;
    logic [31:0]       w_eff32;
    logic [ADDR_W-1:0] w_eff;
    logic [1:0]        w_off;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic              w_mis;
    logic              w_ill;
    logic              w_fault;
    logic              w_accept;

    // Effective address from base plus sign-extended 12-bit immediate.
    always_comb begin
        w_imm   = {{20{imm_MSB[6]}}, imm_MSB, imm_LSB};
        w_eff32 = rs1_data + w_imm;
        w_eff   = w_eff32[ADDR_W-1:0];
        w_off   = w_eff32[1:0];
    end

    // Lane steering and fault classification for the presented store.
    always_comb begin
        w_wdata = rs2_data;
        w_wstrb = 4'b0000;
        w_mis   = 1'b0;
        w_ill   = 1'b0;
        case (funct3)
            c_F3_SB: begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{rs2_data[7:0]}};
            end
            c_F3_SH: begin
                w_wstrb = 4'b0011 << w_off;
                w_wdata = {2{rs2_data[15:0]}};
                w_mis   = w_off[0];
            end
            c_F3_SW: begin
                w_wstrb = 4'b1111;
                w_wdata = rs2_data;
                w_mis   = (w_off != 2'b00);
            end
            default: begin
                w_ill   = 1'b1;
            end
        endcase
        w_fault = w_mis | w_ill;
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_fault ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    w_next = ST_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_FAULT: begin
                done       = 1'b1;
                illegal    = r_ill;
                misaligned = r_mis & ~r_ill;
                w_next     = ST_IDLE;
            end
            ST_ERR: begin
                done    = 1'b1;
                bus_err = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the store on acceptance; it stays stable for the whole request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eff   <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_mis   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            r_eff   <= w_eff;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_mis   <= w_mis;
            r_ill   <= w_ill;
        end
    end

    // Ack-wait counter: cleared on every entry to REQ, counts un-acked cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ && !mem_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Faulting address is loaded for the fault/error done and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_addr <= '0;
        end else if (w_next == ST_FAULT && r_state == ST_IDLE) begin
            r_fault_addr <= w_eff;
        end else if (w_next == ST_ERR && r_state == ST_REQ) begin
            r_fault_addr <= r_eff;
        end
    end

    assign mem_addr   = {r_eff[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign fault_addr = r_fault_addr;

endmodule
`default_nettype wire
